// File: rtl/alu_decode_queue_pkg.sv
// Shared decode constants for the multi-issue ALU decoder queue: MIPS
// opcode/funct/REGIMM fields, the EXE_*_OP alucontrol codes and the invalid
// marker. The optional COP0 decode is enabled by defining ALU_DEC_COP0_EN.
package alu_decode_queue_pkg;

  typedef logic [7:0] alu_op_t;

  localparam alu_op_t ALU_OP_INVALID = 8'hFF;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_BLEZ     = 6'b000110;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_SLTIU    = 6'b001011;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_COP0     = 6'b010000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_LBU      = 6'b100100;
  localparam logic [5:0] OP_LHU      = 6'b100101;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SW       = 6'b101011;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_SLLV    = 6'b000100;
  localparam logic [5:0] FN_SRLV    = 6'b000110;
  localparam logic [5:0] FN_SRAV    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_MOVZ    = 6'b001010;
  localparam logic [5:0] FN_MOVN    = 6'b001011;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_BREAK   = 6'b001101;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SLTU    = 6'b101011;

  // SPECIAL2 funct codes
  localparam logic [5:0] FN2_MADD  = 6'b000000;
  localparam logic [5:0] FN2_MADDU = 6'b000001;
  localparam logic [5:0] FN2_MUL   = 6'b000010;
  localparam logic [5:0] FN2_MSUB  = 6'b000100;
  localparam logic [5:0] FN2_MSUBU = 6'b000101;
  localparam logic [5:0] FN2_CLZ   = 6'b100000;
  localparam logic [5:0] FN2_CLO   = 6'b100001;

  // REGIMM rt codes
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // COP0 rs codes
  localparam logic [4:0] RS_MF = 5'b00000;
  localparam logic [4:0] RS_MT = 5'b00100;

  // alucontrol codes
  localparam alu_op_t EXE_NOP_OP     = 8'b00000000;
  localparam alu_op_t EXE_AND_OP     = 8'b00100100;
  localparam alu_op_t EXE_OR_OP      = 8'b00100101;
  localparam alu_op_t EXE_XOR_OP     = 8'b00100110;
  localparam alu_op_t EXE_NOR_OP     = 8'b00100111;
  localparam alu_op_t EXE_ANDI_OP    = 8'b01011001;
  localparam alu_op_t EXE_ORI_OP     = 8'b01011010;
  localparam alu_op_t EXE_XORI_OP    = 8'b01011011;
  localparam alu_op_t EXE_LUI_OP     = 8'b01011100;
  localparam alu_op_t EXE_SLL_OP     = 8'b01111100;
  localparam alu_op_t EXE_SLLV_OP    = 8'b00000100;
  localparam alu_op_t EXE_SRL_OP     = 8'b00000010;
  localparam alu_op_t EXE_SRLV_OP    = 8'b00000110;
  localparam alu_op_t EXE_SRA_OP     = 8'b00000011;
  localparam alu_op_t EXE_SRAV_OP    = 8'b00000111;
  localparam alu_op_t EXE_MOVZ_OP    = 8'b00001010;
  localparam alu_op_t EXE_MOVN_OP    = 8'b00001011;
  localparam alu_op_t EXE_MFHI_OP    = 8'b00010000;
  localparam alu_op_t EXE_MTHI_OP    = 8'b00010001;
  localparam alu_op_t EXE_MFLO_OP    = 8'b00010010;
  localparam alu_op_t EXE_MTLO_OP    = 8'b00010011;
  localparam alu_op_t EXE_SLT_OP     = 8'b00101010;
  localparam alu_op_t EXE_SLTU_OP    = 8'b00101011;
  localparam alu_op_t EXE_SLTI_OP    = 8'b01010111;
  localparam alu_op_t EXE_SLTIU_OP   = 8'b01011000;
  localparam alu_op_t EXE_ADD_OP     = 8'b00100000;
  localparam alu_op_t EXE_ADDU_OP    = 8'b00100001;
  localparam alu_op_t EXE_SUB_OP     = 8'b00100010;
  localparam alu_op_t EXE_SUBU_OP    = 8'b00100011;
  localparam alu_op_t EXE_ADDI_OP    = 8'b01010101;
  localparam alu_op_t EXE_ADDIU_OP   = 8'b01010110;
  localparam alu_op_t EXE_CLZ_OP     = 8'b10110000;
  localparam alu_op_t EXE_CLO_OP     = 8'b10110001;
  localparam alu_op_t EXE_MULT_OP    = 8'b00011000;
  localparam alu_op_t EXE_MULTU_OP   = 8'b00011001;
  localparam alu_op_t EXE_MUL_OP     = 8'b10101001;
  localparam alu_op_t EXE_MADD_OP    = 8'b10100110;
  localparam alu_op_t EXE_MADDU_OP   = 8'b10101000;
  localparam alu_op_t EXE_MSUB_OP    = 8'b10101010;
  localparam alu_op_t EXE_MSUBU_OP   = 8'b10101011;
  localparam alu_op_t EXE_DIV_OP     = 8'b00011010;
  localparam alu_op_t EXE_DIVU_OP    = 8'b00011011;
  localparam alu_op_t EXE_J_OP       = 8'b01001111;
  localparam alu_op_t EXE_JAL_OP     = 8'b01010000;
  localparam alu_op_t EXE_JALR_OP    = 8'b00001001;
  localparam alu_op_t EXE_JR_OP      = 8'b00001000;
  localparam alu_op_t EXE_BEQ_OP     = 8'b01010001;
  localparam alu_op_t EXE_BGEZ_OP    = 8'b01000001;
  localparam alu_op_t EXE_BGEZAL_OP  = 8'b01001011;
  localparam alu_op_t EXE_BGTZ_OP    = 8'b01010100;
  localparam alu_op_t EXE_BLEZ_OP    = 8'b01010011;
  localparam alu_op_t EXE_BLTZ_OP    = 8'b01000000;
  localparam alu_op_t EXE_BLTZAL_OP  = 8'b01001010;
  localparam alu_op_t EXE_BNE_OP     = 8'b01010010;
  localparam alu_op_t EXE_LB_OP      = 8'b11100000;
  localparam alu_op_t EXE_LBU_OP     = 8'b11100100;
  localparam alu_op_t EXE_LH_OP      = 8'b11100001;
  localparam alu_op_t EXE_LHU_OP     = 8'b11100101;
  localparam alu_op_t EXE_LW_OP      = 8'b11100011;
  localparam alu_op_t EXE_SB_OP      = 8'b11101000;
  localparam alu_op_t EXE_SH_OP      = 8'b11101001;
  localparam alu_op_t EXE_SW_OP      = 8'b11101011;
  localparam alu_op_t EXE_SYSCALL_OP = 8'b00001100;
  localparam alu_op_t EXE_BREAK_OP   = 8'b00001101;
  localparam alu_op_t EXE_MFC0_OP    = 8'b01011101;
  localparam alu_op_t EXE_MTC0_OP    = 8'b01100000;

endpackage

// File: rtl/alu_decode_queue_lane_dec.sv
// Single-lane combinational MIPS decode: instruction word -> alucontrol code
// plus reserved-instruction flag. COP0 moves decode only when
// ALU_DEC_COP0_EN is defined; otherwise every COP0 word is reserved.
module alu_lane_dec
  import alu_decode_queue_pkg::*;
(
  input  logic [31:0] inst,
  output logic [7:0]  alucontrol,
  output logic        invalid
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       unused_bits;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign funct = inst[5:0];

  // Register/immediate fields do not affect the operation class.
  assign unused_bits = ^{inst[25:21], inst[15:6]};

  // Decode op/funct/rt/rs into an alucontrol code; anything unmatched stays invalid.
  always_comb begin
    alucontrol = ALU_OP_INVALID;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_AND:     alucontrol = EXE_AND_OP;
          FN_OR:      alucontrol = EXE_OR_OP;
          FN_XOR:     alucontrol = EXE_XOR_OP;
          FN_NOR:     alucontrol = EXE_NOR_OP;
          FN_SLL:     alucontrol = EXE_SLL_OP;
          FN_SRL:     alucontrol = EXE_SRL_OP;
          FN_SRA:     alucontrol = EXE_SRA_OP;
          FN_SLLV:    alucontrol = EXE_SLLV_OP;
          FN_SRLV:    alucontrol = EXE_SRLV_OP;
          FN_SRAV:    alucontrol = EXE_SRAV_OP;
          FN_MOVZ:    alucontrol = EXE_MOVZ_OP;
          FN_MOVN:    alucontrol = EXE_MOVN_OP;
          FN_MFHI:    alucontrol = EXE_MFHI_OP;
          FN_MTHI:    alucontrol = EXE_MTHI_OP;
          FN_MFLO:    alucontrol = EXE_MFLO_OP;
          FN_MTLO:    alucontrol = EXE_MTLO_OP;
          FN_SLT:     alucontrol = EXE_SLT_OP;
          FN_SLTU:    alucontrol = EXE_SLTU_OP;
          FN_ADD:     alucontrol = EXE_ADD_OP;
          FN_ADDU:    alucontrol = EXE_ADDU_OP;
          FN_SUB:     alucontrol = EXE_SUB_OP;
          FN_SUBU:    alucontrol = EXE_SUBU_OP;
          FN_MULT:    alucontrol = EXE_MULT_OP;
          FN_MULTU:   alucontrol = EXE_MULTU_OP;
          FN_DIV:     alucontrol = EXE_DIV_OP;
          FN_DIVU:    alucontrol = EXE_DIVU_OP;
          FN_JR:      alucontrol = EXE_JR_OP;
          FN_JALR:    alucontrol = EXE_JALR_OP;
          FN_SYSCALL: alucontrol = EXE_SYSCALL_OP;
          FN_BREAK:   alucontrol = EXE_BREAK_OP;
          default:    alucontrol = ALU_OP_INVALID;
        endcase
      end
      OP_SPECIAL2: begin
        case (funct)
          FN2_CLZ:   alucontrol = EXE_CLZ_OP;
          FN2_CLO:   alucontrol = EXE_CLO_OP;
          FN2_MUL:   alucontrol = EXE_MUL_OP;
          FN2_MADD:  alucontrol = EXE_MADD_OP;
          FN2_MADDU: alucontrol = EXE_MADDU_OP;
          FN2_MSUB:  alucontrol = EXE_MSUB_OP;
          FN2_MSUBU: alucontrol = EXE_MSUBU_OP;
          default:   alucontrol = ALU_OP_INVALID;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ:   alucontrol = EXE_BLTZ_OP;
          RT_BGEZ:   alucontrol = EXE_BGEZ_OP;
          RT_BLTZAL: alucontrol = EXE_BLTZAL_OP;
          RT_BGEZAL: alucontrol = EXE_BGEZAL_OP;
          default:   alucontrol = ALU_OP_INVALID;
        endcase
      end
      OP_COP0: begin
`ifdef ALU_DEC_COP0_EN
        case (rs)
          RS_MF:   alucontrol = EXE_MFC0_OP;
          RS_MT:   alucontrol = EXE_MTC0_OP;
          default: alucontrol = ALU_OP_INVALID;
        endcase
`else
        alucontrol = ALU_OP_INVALID;
`endif
      end
      OP_J:     alucontrol = EXE_J_OP;
      OP_JAL:   alucontrol = EXE_JAL_OP;
      OP_BEQ:   alucontrol = EXE_BEQ_OP;
      OP_BNE:   alucontrol = EXE_BNE_OP;
      OP_BLEZ:  alucontrol = EXE_BLEZ_OP;
      OP_BGTZ:  alucontrol = EXE_BGTZ_OP;
      OP_ADDI:  alucontrol = EXE_ADDI_OP;
      OP_ADDIU: alucontrol = EXE_ADDIU_OP;
      OP_SLTI:  alucontrol = EXE_SLTI_OP;
      OP_SLTIU: alucontrol = EXE_SLTIU_OP;
      OP_ANDI:  alucontrol = EXE_ANDI_OP;
      OP_ORI:   alucontrol = EXE_ORI_OP;
      OP_XORI:  alucontrol = EXE_XORI_OP;
      OP_LUI:   alucontrol = EXE_LUI_OP;
      OP_LB:    alucontrol = EXE_LB_OP;
      OP_LH:    alucontrol = EXE_LH_OP;
      OP_LW:    alucontrol = EXE_LW_OP;
      OP_LBU:   alucontrol = EXE_LBU_OP;
      OP_LHU:   alucontrol = EXE_LHU_OP;
      OP_SB:    alucontrol = EXE_SB_OP;
      OP_SH:    alucontrol = EXE_SH_OP;
      OP_SW:    alucontrol = EXE_SW_OP;
      default:  alucontrol = ALU_OP_INVALID;
    endcase
  end

  // No legal instruction maps to the invalid code, so the flag follows it.
  assign invalid = (alucontrol == ALU_OP_INVALID);

endmodule

// File: rtl/alu_decode_queue.sv
// Multi-issue ALU decode queue: decodes ISSUE instruction lanes per cycle and
// buffers the decoded bundles in a DEPTH-entry FIFO with valid/ready on both
// sides, explicit flush and a saturating invalid-lane counter.
// Optional COP0 decode in the lanes: define ALU_DEC_COP0_EN.
module alu_decode_queue
  import alu_decode_queue_pkg::*;
#(
  parameter int ISSUE = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ISSUE-1:0]     in_valid,
  input  logic [32*ISSUE-1:0]  in_inst,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ISSUE-1:0]     out_lane_valid,
  output logic [8*ISSUE-1:0]   out_alucontrol,
  output logic [ISSUE-1:0]     out_invalid,
  output logic [CNT_W-1:0]     invalid_cnt
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

  // Number of set lanes in a mask (ISSUE <= 4 fits in 3 bits).
  function automatic logic [2:0] lane_popcount(input logic [ISSUE-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < ISSUE; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // Add with saturation at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [2:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    if (s[CNT_W]) return '1;
    return s[CNT_W-1:0];
  endfunction

  logic [8*ISSUE-1:0] dec_alu;
  logic [ISSUE-1:0]   dec_inv;
  logic [8*ISSUE-1:0] wr_alu;
  logic [ISSUE-1:0]   wr_inv;

  logic [ISSUE-1:0]   mem_lv  [DEPTH];
  logic [8*ISSUE-1:0] mem_alu [DEPTH];
  logic [ISSUE-1:0]   mem_inv [DEPTH];

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               push;
  logic               pop;

  // Decode each lane; unused lanes become invalid-code but unflagged.
  for (genvar g = 0; g < ISSUE; g++) begin : g_lane
    alu_lane_dec u_dec (
      .inst       (in_inst[32*g +: 32]),
      .alucontrol (dec_alu[8*g +: 8]),
      .invalid    (dec_inv[g])
    );
    assign wr_alu[8*g +: 8] = in_valid[g] ? dec_alu[8*g +: 8] : ALU_OP_INVALID;
    assign wr_inv[g]        = in_valid[g] & dec_inv[g];
  end

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = (|in_valid) && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Head outputs come straight from storage, masked to empty values when idle.
  assign out_lane_valid = out_valid ? mem_lv[rd_ptr]  : '0;
  assign out_alucontrol = out_valid ? mem_alu[rd_ptr] : {ISSUE{ALU_OP_INVALID}};
  assign out_invalid    = out_valid ? mem_inv[rd_ptr] : '0;

  // Bundle storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_lv[wr_ptr]  <= in_valid;
      mem_alu[wr_ptr] <= wr_alu;
      mem_inv[wr_ptr] <= wr_inv;
    end
  end

  // Pointer and occupancy control; flush wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Invalid-lane counter survives flush and only counts accepted pushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) invalid_cnt <= '0;
    else if (push) invalid_cnt <= sat_add(invalid_cnt, lane_popcount(wr_inv));
  end

endmodule

// File: tb/tb_alu_decode_queue.sv
// Directed self-checking bench for alu_decode_queue (ISSUE=2, DEPTH=4, CNT_W=4).
module tb_alu_decode_queue;

  localparam int ISSUE = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [ISSUE-1:0]    in_valid = '0;
  logic [32*ISSUE-1:0] in_inst = '0;
  logic                in_ready;
  logic                flush = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [ISSUE-1:0]    out_lane_valid;
  logic [8*ISSUE-1:0]  out_alucontrol;
  logic [ISSUE-1:0]    out_invalid;
  logic [CNT_W-1:0]    invalid_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  alu_decode_queue #(.ISSUE(ISSUE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_inst        (in_inst),
    .in_ready       (in_ready),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane_valid (out_lane_valid),
    .out_alucontrol (out_alucontrol),
    .out_invalid    (out_invalid),
    .invalid_cnt    (invalid_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drain-order bundles: {lane1, lane0} instruction words and decoded codes.
  logic [63:0] fill_inst [5] = '{
    {32'h00000020, 32'h34000000},  // ADD , ORI
    {32'h00000022, 32'h30000000},  // SUB , ANDI
    {32'h08000000, 32'h38000000},  // J   , XORI
    {32'h10000000, 32'h3C000000},  // BEQ , LUI
    {32'h04110000, 32'h8C000000}   // BGEZAL, LW (never accepted)
  };
  logic [15:0] fill_alu [4] = '{16'h205A, 16'h2259, 16'h4F5B, 16'h515C};

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_cnt", 32'(invalid_cnt), 32'h0);
    check("rst_alu", 32'(out_alucontrol), 32'hFFFF);
    check("rst_lane_valid", 32'(out_lane_valid), 32'h0);
    check("rst_invalid", 32'(out_invalid), 32'h0);
    rst = 1'b0;
    tick();

    // ORI / ADD bundle, consumer ready
    out_ready = 1'b1;
    in_valid  = 2'b11;
    in_inst   = {32'h00221820, 32'h34010001};
    tick();
    in_valid = 2'b00;
    check("b1_out_valid", 32'(out_valid), 32'h1);
    check("b1_alu", 32'(out_alucontrol), 32'h205A);
    check("b1_invalid", 32'(out_invalid), 32'h0);
    check("b1_lane_valid", 32'(out_lane_valid), 32'h3);
    tick();
    check("b1_popped", 32'(out_valid), 32'h0);

    // Reserved opcode in lane0, lane1 idle
    in_valid = 2'b01;
    in_inst  = {32'h34010001, 32'hFC000000};
    tick();
    in_valid = 2'b00;
    exp_cnt  = 1;
    check("b2_alu", 32'(out_alucontrol), 32'hFFFF);
    check("b2_invalid", 32'(out_invalid), 32'h1);
    check("b2_lane_valid", 32'(out_lane_valid), 32'h1);
    check("b2_cnt", 32'(invalid_cnt), 32'(exp_cnt));
    tick();
    check("b2_popped", 32'(out_valid), 32'h0);

    // Fill past capacity with consumer stalled, then drain across the wrap
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("fill_in_ready_%0d", k), 32'(in_ready), (k < DEPTH) ? 32'h1 : 32'h0);
      in_valid = 2'b11;
      in_inst  = fill_inst[k];
      tick();
    end
    in_valid = 2'b00;
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_head_stable", 32'(out_alucontrol), 32'(fill_alu[0]));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_valid_%0d", k), 32'(out_valid), 32'h1);
      check($sformatf("drain_alu_%0d", k), 32'(out_alucontrol), 32'(fill_alu[k]));
      tick();
    end
    check("drain_empty", 32'(out_valid), 32'h0);
    check("drain_in_ready", 32'(in_ready), 32'h1);
    check("drain_cnt", 32'(invalid_cnt), 32'(exp_cnt));

    // Flush a full queue while pushing
    out_ready = 1'b0;
    in_valid  = 2'b11;
    in_inst   = {32'h00221820, 32'h34010001};
    for (int k = 0; k < DEPTH; k++) tick();
    check("pre_flush_full", 32'(in_ready), 32'h0);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_inst   = {32'hFC000000, 32'hFC000000};
    tick();
    flush = 1'b0;
    in_valid = 2'b00;
    check("flush_full_valid", 32'(out_valid), 32'h0);
    check("flush_full_ready", 32'(in_ready), 32'h1);
    check("flush_full_cnt", 32'(invalid_cnt), 32'(exp_cnt));

    // Flush a partly filled queue while an acceptable invalid push is offered
    out_ready = 1'b0;
    in_valid  = 2'b11;
    in_inst   = {32'h00221820, 32'h34010001};
    tick();
    flush   = 1'b1;
    in_inst = {32'hFC000000, 32'hFC000000};
    tick();
    flush    = 1'b0;
    in_valid = 2'b00;
    check("flush_part_valid", 32'(out_valid), 32'h0);
    check("flush_part_cnt", 32'(invalid_cnt), 32'(exp_cnt));

    // Queue usable after flush
    in_valid = 2'b11;
    in_inst  = {32'h00000022, 32'h30000000};
    tick();
    in_valid  = 2'b00;
    check("post_flush_alu", 32'(out_alucontrol), 32'h2259);
    out_ready = 1'b1;
    tick();
    check("post_flush_empty", 32'(out_valid), 32'h0);

    // MTC0
    in_valid = 2'b01;
    in_inst  = {32'h00000000, 32'h40806000};
    tick();
    in_valid = 2'b00;
`ifdef ALU_DEC_COP0_EN
    check("mtc0_alu", 32'(out_alucontrol), 32'hFF60);
    check("mtc0_invalid", 32'(out_invalid), 32'h0);
`else
    exp_cnt = exp_cnt + 1;
    check("mtc0_alu", 32'(out_alucontrol), 32'hFFFF);
    check("mtc0_invalid", 32'(out_invalid), 32'h1);
`endif
    check("mtc0_cnt", 32'(invalid_cnt), 32'(exp_cnt));
    tick();

    // Preload the counter to max-1 with single invalid lanes (push+pop each cycle)
    in_inst = {32'hFC000000, 32'hFC000000};
    while (exp_cnt < 14) begin
      in_valid = 2'b01;
      tick();
      exp_cnt = exp_cnt + 1;
    end
    in_valid = 2'b00;
    check("sat_pre", 32'(invalid_cnt), 32'd14);
    in_valid = 2'b11;
    tick();
    check("sat_hit", 32'(invalid_cnt), 32'd15);
    tick();
    in_valid = 2'b00;
    check("sat_hold", 32'(invalid_cnt), 32'd15);
    check("sat_head_inv", 32'(out_invalid), 32'h3);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    in_valid  = 2'b11;
    in_inst   = {32'h00221820, 32'h34010001};
    tick();
    in_valid = 2'b00;
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_cnt", 32'(invalid_cnt), 32'h0);
    check("async_rst_alu", 32'(out_alucontrol), 32'hFFFF);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
